// File: rtl/ahb_sram_responder.sv
// AHB-Lite responder over a word-wide SRAM; AHB_SRAM_WPROT_EN rejects writes to the low PROT_WORDS words.
// Latency: read data from the first data-phase cycle, OKAY after WAIT_STATES stall cycles, ERROR takes two cycles.
// Backpressure: HREADY low stalls the bus; a new address phase is only taken while HREADY is high.
module ahb_sram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned PROT_WORDS  = 64
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic        HREADY,
    output logic        HRESP,
    output logic [31:0] HRDATA
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
    localparam logic [3:0]  WS4  = 4'(WAIT_STATES);

    if (BASE_ADDR[1:0] != 2'b00 || DEPTH < 16 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0
        || WAIT_STATES > 15 || PROT_WORDS > DEPTH) begin : g_bad_cfg
        $error("ahb_sram_responder: illegal parameter set");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t        state, state_d;
    logic [3:0]    wait_cnt, wait_cnt_d;
    logic [31:0]   mem [DEPTH];

    logic [32:0]   diff;
    logic [31:0]   offset;
    logic [AW-1:0] acc_idx, wr_idx;
    logic [3:0]    acc_be, wr_be;
    logic          wr_pend;
    logic          accept, acc_err, acc_ok;
    logic          range_err, size_err, align_err, prot_err;
    logic          complete, do_write, fwd_hit;
    logic [31:0]   rd_word, fwd_word, rdata_q;

    // A 33-bit difference folds the below-base case into the span compare via the borrow bit.
    assign diff    = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    assign offset  = diff[31:0];
    assign acc_idx = offset[AW+1:2];
    assign accept  = HSEL && (HTRANS inside {2'b10, 2'b11}) && HREADY;
    assign acc_ok  = accept && !acc_err;

    always_comb begin
        range_err = diff >= SPAN;
        size_err  = HSIZE > 3'd2;
        align_err = (HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
`ifdef AHB_SRAM_WPROT_EN
        prot_err  = HWRITE && ({2'b00, offset[31:2]} < 32'(PROT_WORDS));
`else
        prot_err  = 1'b0;
`endif
        acc_err   = range_err || size_err || align_err || prot_err;
        case (HSIZE)
            3'd0:    acc_be = 4'b0001 << HADDR[1:0];
            3'd1:    acc_be = HADDR[1] ? 4'b1100 : 4'b0011;
            default: acc_be = 4'b1111;
        endcase
    end

    // Bus outputs depend on state only, so accept never loops back through HREADY.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        unique case (state)
            ST_DATA: HREADY = (wait_cnt == 4'd0);
            ST_ERR1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end
            ST_ERR2: HRESP = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        unique case (state)
            ST_IDLE: state_d = ST_IDLE;
            ST_DATA: begin
                if (wait_cnt != 4'd0) wait_cnt_d = wait_cnt - 4'd1;
                else                  state_d    = ST_IDLE;
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d    = acc_err ? ST_ERR1 : ST_DATA;
            wait_cnt_d = acc_err ? 4'd0 : WS4;
        end
    end

    assign complete = (state == ST_DATA) && (wait_cnt == 4'd0);
    assign do_write = complete && wr_pend;
    assign rd_word  = mem[acc_idx];
    assign fwd_hit  = do_write && (wr_idx == acc_idx);

    // A read landing on the word being written this cycle sees the merged result.
    always_comb begin
        fwd_word = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) fwd_word[8*b +: 8] = HWDATA[8*b +: 8];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            wr_pend  <= 1'b0;
            wr_idx   <= '0;
            wr_be    <= 4'd0;
            rdata_q  <= 32'd0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            if (accept) begin
                wr_pend <= acc_ok && HWRITE;
                wr_idx  <= acc_idx;
                wr_be   <= acc_be;
            end else if (complete) begin
                wr_pend <= 1'b0;
            end
            if (acc_ok && !HWRITE) rdata_q <= fwd_hit ? fwd_word : rd_word;
        end
    end

    // SRAM array is never cleared; reset only blocks a write that would complete this cycle.
    always_ff @(posedge HCLK) begin
        if (!HRESET && do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    assign HRDATA = rdata_q;

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Bench for ahb_sram_responder: two instances (zero and three wait states) driven by a pipelined AHB driver
// with a reference memory model feeding a scoreboard of expected responses.
module tb_ahb_sram_responder;
    localparam logic [31:0] B0 = 32'h2000_0000;
    localparam int          D0 = 1024;
    localparam int          W0 = 0;
    localparam logic [31:0] B1 = 32'h0000_0000;
    localparam int          D1 = 256;
    localparam int          W1 = 3;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        err;
        logic        chk;
        logic        wr;
        logic [31:0] rdata;
        logic [31:0] waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel0, hsel1;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready0, hresp0, hready1, hresp1;
    logic [31:0] hrdata0, hrdata1;

    int checks = 0;
    int failures = 0;

    req_t        pend[$];
    exp_t        sb[$];
    logic [31:0] mm [int];

    always #5 clk = ~clk;

    ahb_sram_responder #(.BASE_ADDR(B0), .DEPTH(D0), .WAIT_STATES(W0), .PROT_WORDS(64)) dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready0), .HRESP(hresp0), .HRDATA(hrdata0));

    ahb_sram_responder #(.BASE_ADDR(B1), .DEPTH(D1), .WAIT_STATES(W1), .PROT_WORDS(64)) dut1 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready1), .HRESP(hresp1), .HRDATA(hrdata1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_err(input bit d1, input req_t r);
        logic [31:0] base;
        logic [31:0] last;
        base = d1 ? B1 : B0;
        last = base + 32'(4 * (d1 ? D1 : D0)) - 32'd1;
        if (r.addr < base || r.addr > last) return 1'b1;
        if (r.size > 3'd2) return 1'b1;
        if (r.size == 3'd1 && r.addr[0]) return 1'b1;
        if (r.size == 3'd2 && r.addr[1:0] != 2'b00) return 1'b1;
`ifdef AHB_SRAM_WPROT_EN
        if (r.wr && ((r.addr - base) >> 2) < 32'd64) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Sequential memory semantics: each transfer sees every earlier write in issue order.
    function automatic exp_t model(input bit d1, input req_t r);
        exp_t        e;
        int          key;
        logic [31:0] w;
        logic [3:0]  be;
        e       = '0;
        e.wr    = r.wr;
        e.err   = m_err(d1, r);
        e.waits = e.err ? 32'd1 : 32'(d1 ? W1 : W0);
        if (!e.err) begin
            key = (d1 ? 65536 : 0) + int'((r.addr - (d1 ? B1 : B0)) >> 2);
            if (r.wr) begin
                if (r.size == 3'd0)      be = 4'b0001 << r.addr[1:0];
                else if (r.size == 3'd1) be = r.addr[1] ? 4'b1100 : 4'b0011;
                else                     be = 4'b1111;
                w = mm.exists(key) ? mm[key] : 32'h0;
                for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = r.wdata[8*b +: 8];
                mm[key] = w;
            end else if (mm.exists(key)) begin
                e.chk   = 1'b1;
                e.rdata = mm[key];
            end
        end
        return e;
    endfunction

    task automatic q(input logic wr, input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        req_t r;
        r.wr = wr; r.addr = addr; r.size = size; r.wdata = wdata;
        pend.push_back(r);
    endtask

    // Pipelined driver: address phase of the next request overlaps the data phase of the current one.
    task automatic run(input bit d1);
        req_t cur, nxt;
        exp_t e;
        bit   busy, have;
        int   waits;
        busy = 1'b0;
        cur  = '0;
        while (pend.size() > 0 || busy) begin
            nxt  = '0;
            have = pend.size() > 0;
            if (have) begin
                nxt    = pend.pop_front();
                hsel0  = !d1;
                hsel1  = d1;
                htrans = busy ? 2'b11 : 2'b10;
                haddr  = nxt.addr;
                hwrite = nxt.wr;
                hsize  = nxt.size;
                sb.push_back(model(d1, nxt));
            end else begin
                hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00;
                haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0;
            end
            hwdata = (busy && cur.wr) ? cur.wdata : 32'h0;
            waits  = 0;
            @(negedge clk);
            while (!(d1 ? hready1 : hready0) && waits < 50) begin
                if (busy) check("stall_hresp", 32'(d1 ? hresp1 : hresp0), 32'(sb[0].err));
                waits++;
                @(negedge clk);
            end
            if (busy) begin
                e = sb.pop_front();
                check("hresp", 32'(d1 ? hresp1 : hresp0), 32'(e.err));
                check("wait_cycles", 32'(waits), e.waits);
                if (!e.wr && !e.err && e.chk) check("hrdata", d1 ? hrdata1 : hrdata0, e.rdata);
            end else begin
                check("addr_only_wait", 32'(waits), 32'd0);
            end
            @(posedge clk);
            #1;
            busy = have;
            cur  = nxt;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; hsel0 = 1'b0; hsel1 = 1'b0; haddr = 32'h0; htrans = 2'b00;
        hwrite = 1'b0; hsize = 3'd0; hwdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_hready0", 32'(hready0), 32'd1);
        check("rst_hresp0", 32'(hresp0), 32'd0);
        check("rst_hrdata0", hrdata0, 32'h0);
        check("rst_hready1", 32'(hready1), 32'd1);
        check("rst_hresp1", 32'(hresp1), 32'd0);
        check("rst_hrdata1", hrdata1, 32'h0);
        @(posedge clk);
        #1;

        // Byte lane merge, then word write and readback
        q(1, B0 + 32'h10, 3'd2, 32'h1122_3344);
        q(1, B0 + 32'h13, 3'd0, 32'hAA00_0000);
        q(0, B0 + 32'h10, 3'd2, 32'h0);
        q(1, B0 + 32'h10, 3'd2, 32'hDEAD_BEEF);
        q(0, B0 + 32'h10, 3'd2, 32'h0);
        run(0);

        // Error cases and range boundaries
        q(0, B0 + 32'(4 * D0), 3'd2, 32'h0);
        q(0, B0 + 32'h1, 3'd1, 32'h0);
        q(1, B0 + 32'h10, 3'd3, 32'h0BAD_0BAD);
        q(0, B0 - 32'h4, 3'd2, 32'h0);
        q(1, B0 + 32'h12, 3'd2, 32'h0BAD_0BAD);
        q(0, B0 + 32'h10, 3'd2, 32'h0);
        q(1, B0 + 32'(4 * D0) - 32'h4, 3'd2, 32'h0102_0304);
        q(0, B0 + 32'(4 * D0) - 32'h4, 3'd2, 32'h0);
        run(0);

        // Read-after-write forwarding, with and without a word match
        q(1, B0 + 32'h24, 3'd2, 32'h0BAD_F00D);
        run(0);
        q(1, B0 + 32'h20, 3'd2, 32'h5566_7788);
        q(0, B0 + 32'h20, 3'd2, 32'h0);
        q(1, B0 + 32'h22, 3'd1, 32'hBEEF_0000);
        q(0, B0 + 32'h20, 3'd2, 32'h0);
        q(1, B0 + 32'h20, 3'd2, 32'h99AA_BBCC);
        q(0, B0 + 32'h24, 3'd2, 32'h0);
        q(0, B0 + 32'h20, 3'd2, 32'h0);
        run(0);

        // Protected-region boundary
        q(1, B0 + 32'h40, 3'd2, 32'h7777_7777);
        q(0, B0 + 32'h40, 3'd2, 32'h0);
        q(1, B0 + 32'h100, 3'd2, 32'h1212_1212);
        q(0, B0 + 32'h100, 3'd2, 32'h0);
        run(0);

        // BUSY and unselected address phases give zero-wait OKAY with no access
        hsel0 = 1'b1; htrans = 2'b01; haddr = B0 + 32'h10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk);
        #1 hsel0 = 1'b0; htrans = 2'b10; hwdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("busy_hready", 32'(hready0), 32'd1);
        check("busy_hresp", 32'(hresp0), 32'd0);
        @(posedge clk);
        #1 htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hwdata = 32'h0;
        @(negedge clk);
        check("nosel_hready", 32'(hready0), 32'd1);
        @(posedge clk);
        #1;
        q(0, B0 + 32'h10, 3'd2, 32'h0);
        run(0);

        // Three wait states; an error still takes no wait states before ERR1
        q(1, B1 + 32'h300, 3'd2, 32'hCAFE_F00D);
        q(0, B1 + 32'h300, 3'd2, 32'h0);
        q(0, B1 + 32'(4 * D1), 3'd2, 32'h0);
        q(0, B1 + 32'h300, 3'd2, 32'h0);
        run(1);

        // Reset on the completing cycle of a stalled write aborts it
        hsel1 = 1'b1; htrans = 2'b10; haddr = B1 + 32'h300; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk);
        #1 hsel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hwdata = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("ws3_last_hready", 32'(hready1), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0; hwdata = 32'h0;
        @(negedge clk);
        check("post_rst_hready", 32'(hready1), 32'd1);
        check("post_rst_hresp", 32'(hresp1), 32'd0);
        check("post_rst_hrdata", hrdata1, 32'h0);
        @(posedge clk);
        #1;
        q(0, B1 + 32'h300, 3'd2, 32'h0);
        run(1);
        q(0, B0 + 32'h10, 3'd2, 32'h0);
        run(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_sram_responder.md
Name: ahb_sram_responder

Overview:
- AHB-Lite responder fronting an on-chip word-organised SRAM; the subordinate end of the bus driven by the jtag debug bridge.
- Decodes address phase, inserts programmable wait states, performs byte/halfword/word writes and word reads.
- Returns OKAY/ERROR responses with correct two-cycle ERROR sequencing.
- Single-manager system: HREADY is driven by this block and is also the bus HREADY it samples.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- DEPTH, 1024, number of 32-bit words; power of two, 16..65536.
- WAIT_STATES, 0, HREADY-low cycles per data phase; 0..15.
- PROT_WORDS, 64, number of write-protected words from BASE_ADDR; used only with AHB_SRAM_WPROT_EN.

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  subordinate select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 halfword, 010 word.
- HWDATA  in  32  write data, data phase.
- HREADY  out  1  transfer done / bus ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data.

Behaviour:
- Reset: HREADY=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, pending write discarded. SRAM contents are not cleared. Reset mid-transfer aborts the transfer with no SRAM write.
- Accept: an address phase is accepted when HSEL & HTRANS[1] & HREADY. IDLE/BUSY, or HSEL=0, gives a zero-wait OKAY with no access.
- Error check at accept. ERROR if any of:
  - address outside BASE_ADDR..BASE_ADDR+4*DEPTH-1;
  - HSIZE>2;
  - misaligned (halfword with HADDR[0]=1; word with HADDR[1:0]!=0).
- FSM states:
  - IDLE: no data phase pending.
  - DATA: OKAY data phase.
  - ERR1: HREADY=0, HRESP=1.
  - ERR2: HREADY=1, HRESP=1.
- Transitions:
  - Accepted OK transfer → DATA, counter loaded with WAIT_STATES.
  - DATA: HREADY=0 while counter≠0, decrement each cycle. Counter=0 → HREADY=1, HRESP=0, transfer completes.
  - Accepted errored transfer → ERR1 → ERR2 unconditionally; no wait states inserted before ERR1.
  - In ERR2 and in the completing DATA cycle, a new address phase can be accepted. Next state follows that new transfer, otherwise IDLE.
- Reads:
  - SRAM read issued on the accept cycle, word index (HADDR-BASE_ADDR)>>2.
  - Captured data driven on HRDATA from the first data-phase cycle and held until the next read completes.
  - All 32 bits returned regardless of HSIZE.
- Writes:
  - HWDATA sampled on the completing (HREADY=1) data-phase cycle only.
  - Byte enables from HSIZE and HADDR[1:0] latched at accept.
  - Little-endian lanes: byte n = HWDATA[8n+7:8n].
- Read-after-write forwarding:
  - Case: a read is accepted in the same cycle a write's data phase completes, to the same word.
  - HRDATA must equal the old word with the enabled write bytes replaced by the new HWDATA bytes.
  - Different word: no forwarding.
- Back-to-back transfers with WAIT_STATES=0 sustain one transfer per cycle.
- Errored transfers never modify SRAM.

Optional Feature:
- Macro: AHB_SRAM_WPROT_EN.
- Defined: writes to words 0..PROT_WORDS-1 are rejected at accept with the two-cycle ERROR response, and SRAM is unchanged. Reads there remain OKAY.
- Undefined: PROT_WORDS is ignored and the whole range is writable.

Test Plan:
- Reset then word write 0xDEADBEEF to BASE+0x10, read it back, WAIT_STATES=0 → HRESP=0, HREADY never low, HRDATA=0xDEADBEEF.
- Byte write 0xAA to BASE+0x13 over word 0x11223344, then word read → HRDATA=0xAA223344.
- WAIT_STATES=3, single read → HREADY low exactly 3 cycles, data valid on 4th data-phase cycle.
- Word read at BASE+4*DEPTH, and halfword at BASE+0x1 → each gives ERR1 (HREADY=0, HRESP=1) then ERR2 (HREADY=1, HRESP=1); subsequent read of BASE+0x10 returns unchanged 0xDEADBEEF.
- Pipelined word write 0x55667788 to BASE+0x20 immediately followed by read of BASE+0x20 → read returns 0x55667788 (forwarding); repeat to BASE+0x24 → returns prior contents.
- With AHB_SRAM_WPROT_EN, PROT_WORDS=64: write to BASE+0x40 → ERROR, readback unchanged; write to BASE+0x100 → OKAY. HRESET asserted during a 3-wait-state write → no SRAM change, HREADY=1 on the cycle after reset.
